// File: rtl/cluster_icache_flush_seq.sv
// Instruction-cache flush sequencer: flushes the L1 first (when requested),
// then all selected L0 fetch ports concurrently, and counts completed sequences.
module cluster_icache_flush_seq #(
  parameter int NR_FETCH_PORTS = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [NR_FETCH_PORTS-1:0] req_l0_mask_i,
  input  logic                      req_l1_i,
  output logic                      l1_flush_valid_o,
  input  logic                      l1_flush_ready_i,
  output logic [NR_FETCH_PORTS-1:0] l0_flush_valid_o,
  input  logic [NR_FETCH_PORTS-1:0] l0_flush_ready_i,
  output logic [NR_FETCH_PORTS-1:0] pending_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      seq_count_o,
  output logic [1:0]                state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid, once raised, stays high until that edge, and a ready
  // whose valid is low has no effect.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    L1_FLUSH = 2'd1,
    L0_FLUSH = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [NR_FETCH_PORTS-1:0]   pending_q, pending_d;
  logic                        l1_q, l1_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      l1_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      l1_q      <= l1_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    l1_d      = l1_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          pending_d = req_l0_mask_i;
          l1_d      = req_l1_i;
          if (req_l1_i)                 state_d = L1_FLUSH;
          else if (req_l0_mask_i != '0) state_d = L0_FLUSH;
          else                          state_d = DONE;
        end
      end
      L1_FLUSH: begin
        if (l1_flush_ready_i) begin
          l1_d    = 1'b0;
          state_d = (pending_q != '0) ? L0_FLUSH : DONE;
        end
      end
      L0_FLUSH: begin
        // Only ports still pending can complete; stray readies are masked out.
        pending_d = pending_q & ~(pending_q & l0_flush_ready_i);
        if (pending_d == '0) state_d = DONE;
      end
      DONE: begin
        count_d = count_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o      = (state_q == IDLE);
  assign l1_flush_valid_o = (state_q == L1_FLUSH) && l1_q;
  assign l0_flush_valid_o = (state_q == L0_FLUSH) ? pending_q : '0;
  assign pending_o        = pending_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign seq_count_o      = count_q;
  assign state_o          = state_q;

endmodule

// File: doc/cluster_icache_flush_seq.md
CLUSTER_ICACHE_FLUSH_SEQ -- requirements
Module: cluster_icache_flush_seq

Interface
REQ-001 SHALL have parameter NR_FETCH_PORTS, default 1, number of L0 fetch ports sequenced (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the completed-sequence counter.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  flush request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-007 SHALL have port req_l0_mask_i  input  NR_FETCH_PORTS  L0 ports to flush.
REQ-008 SHALL have port req_l1_i  input  1  also flush the L1.
REQ-009 SHALL have port l1_flush_valid_o  output  1  L1 flush request.
REQ-010 SHALL have port l1_flush_ready_i  input  1  L1 flush acknowledge.
REQ-011 SHALL have port l0_flush_valid_o  output  NR_FETCH_PORTS  per-port L0 flush request.
REQ-012 SHALL have port l0_flush_ready_i  input  NR_FETCH_PORTS  per-port L0 flush acknowledge.
REQ-013 SHALL have port pending_o  output  NR_FETCH_PORTS  L0 ports not yet acknowledged in current sequence.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse at sequence completion.
REQ-016 SHALL have port seq_count_o  output  CNT_WIDTH  number of completed sequences.

Function
REQ-017 SHALL implement FSM states IDLE, L1_FLUSH, L0_FLUSH, DONE.
REQ-018 SHALL drive req_ready_o = (state == IDLE); no request accepted in any other state.
REQ-019 SHALL on accept capture req_l0_mask_i into pending register and req_l1_i into l1 flag.
REQ-020 SHALL on accept transition: req_l1_i=1 -> L1_FLUSH; else mask!=0 -> L0_FLUSH; else -> DONE.
REQ-021 SHALL order flushes L1 first, then L0; no l0_flush_valid_o bit high while in L1_FLUSH.
REQ-022 SHALL in L1_FLUSH hold l1_flush_valid_o high until l1_flush_ready_i sampled high; valid never drops before handshake.
REQ-023 SHALL on L1 handshake go to L0_FLUSH if pending!=0, else DONE.
REQ-024 SHALL drive l0_flush_valid_o = pending when state==L0_FLUSH, else 0; all pending ports requested concurrently.
REQ-025 SHALL clear pending[i] on the edge where l0_flush_valid_o[i] & l0_flush_ready_i[i]; other bits unaffected.
REQ-026 SHALL leave L0_FLUSH for DONE on the same edge the last pending bit clears (simultaneous acknowledges allowed).
REQ-027 SHALL ignore ready inputs whose corresponding valid is low.
REQ-028 SHALL in DONE assert done_o for exactly one cycle, increment seq_count_o, return to IDLE next edge.
REQ-029 SHALL let seq_count_o wrap from all-ones to 0.
REQ-030 SHALL drive all outputs from registered state only (no combinational path from inputs to outputs).
REQ-031 SHALL, with all readies tied high, have L1+L0 request: accept t0, L1 valid t1, L0 valid t2, done_o t3, req_ready_o t4.
REQ-032 SHALL ignore req_l0_mask_i and req_l1_i changes after acceptance.

Reset
REQ-033 SHALL on rst_ni low asynchronously enter IDLE, clear pending, l1 flag, seq_count_o.
REQ-034 SHALL reset outputs: req_ready_o=1, l1_flush_valid_o=0, l0_flush_valid_o=0, pending_o=0, busy_o=0, done_o=0, seq_count_o=0.
REQ-035 SHALL on reset mid-sequence drop all flush valids immediately; the aborted sequence is not counted and produces no done_o.

Verification
REQ-036 SHALL cover: N=4, mask=4'b0101, l1=0, readies high -> valid 0101 at t1, done_o t2, seq_count_o=1.
REQ-037 SHALL cover: l1=1, mask=4'b1111, l1 ready delayed 5 cycles -> l1 valid held 5 cycles, no L0 valid until after handshake, then 1111.
REQ-038 SHALL cover: mask=4'b1111, readies staggered port0..3 one per cycle -> pending 1110,1100,1000,0000; done_o one cycle after last.
REQ-039 SHALL cover: mask=0, l1=0 -> DONE at t1, done_o pulse, no flush valids, count increments.
REQ-040 SHALL cover: second req_valid_i held during busy -> not accepted until IDLE, then accepted with its own mask.
REQ-041 SHALL cover: rst_ni asserted in L0_FLUSH with pending=0110 -> valids 0 immediately, pending_o=0, seq_count_o=0, no done_o.
